// File: rtl/rgbled_sched_pkg.sv
// Shared types and constants for the RGB LED frame scheduler.
// The scheduler FSM states and the three test-pattern colours (24-bit GRB) live here.
package rgbled_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ACK,
    BUSY,
    GAP
  } state_e;

  localparam logic [23:0] COLOUR0 = 24'hFF0000;
  localparam logic [23:0] COLOUR1 = 24'h00FF00;
  localparam logic [23:0] COLOUR2 = 24'h0000FF;

  function automatic logic [23:0] colour_of(input int idx);
    case (idx)
      0:       return COLOUR0;
      1:       return COLOUR1;
      default: return COLOUR2;
    endcase
  endfunction

endpackage

// File: rtl/rgbled_pattern_gen.sv
// Test-pattern frame generator: LED i shows colour[(step+i) mod 3].
// Purely combinational; the owning scheduler holds the step register.
module rgbled_pattern_gen
  import rgbled_sched_pkg::*;
#(
  parameter int LEDS         = 3,
  parameter int BITS_PER_LED = 24
) (
  input  logic [1:0]                   step,
  input  logic                         advance,
  output logic [1:0]                   step_next,
  output logic [LEDS*BITS_PER_LED-1:0] frame
);

  // Colours are 24 bits wide; wider LEDs get zero-extension, narrower keep the low bits.
  function automatic logic [BITS_PER_LED-1:0] fit_colour(input logic [23:0] c);
    return BITS_PER_LED'(c);
  endfunction

  always_comb begin
    frame = '0;
    for (int i = 0; i < LEDS; i++) begin
      frame[i*BITS_PER_LED +: BITS_PER_LED] = fit_colour(colour_of((int'(step) + i) % 3));
    end
  end

  always_comb begin
    step_next = step;
    if (advance) begin
      step_next = (step >= 2'd2) ? 2'd0 : step + 2'd1;
    end
  end

endmodule

// File: rtl/rgbled_scheduler.sv
// Schedules SPI frames (and optional test-pattern frames) onto a serial LED driver.
// Define RGBLED_SCHED_PATTERN_EN to compile in the autonomous test-pattern source.
module rgbled_scheduler
  import rgbled_sched_pkg::*;
#(
  parameter int LEDS         = 3,
  parameter int BITS_PER_LED = 24,
  parameter int GAP_CYCLES   = 500,
  parameter int ACK_TIMEOUT  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LEDS*BITS_PER_LED-1:0] spi_data,
  input  logic                         spi_rdy,
  input  logic                         pattern_en,
  input  logic                         led_busy,
  output logic [LEDS*BITS_PER_LED-1:0] led_data,
  output logic                         led_rdy,
  output logic                         src,
  output logic [7:0]                   drop_cnt
);

  localparam int FRAME_W = LEDS * BITS_PER_LED;
  localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   pend_buf_q, pend_buf_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [FRAME_W-1:0]   led_data_q, led_data_d;
  logic [7:0]           drop_q, drop_d;
  logic                 launch_spi, launch_pat;
  logic                 pat_eligible;
  logic [FRAME_W-1:0]   pat_frame;

`ifdef RGBLED_SCHED_PATTERN_EN
  logic [1:0] step_q, step_d;
  logic       src_q, src_d;

  rgbled_pattern_gen #(
    .LEDS         (LEDS),
    .BITS_PER_LED (BITS_PER_LED)
  ) u_pattern_gen (
    .step      (step_q),
    .advance   (launch_pat),
    .step_next (step_d),
    .frame     (pat_frame)
  );

  assign pat_eligible = pattern_en;

  always_comb begin
    src_d = src_q;
    if (launch_spi) begin
      src_d = 1'b0;
    end else if (launch_pat) begin
      src_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= 2'd0;
      src_q  <= 1'b0;
    end else begin
      step_q <= step_d;
      src_q  <= src_d;
    end
  end

  assign src = src_q;
`else
  logic unused_pattern_en;
  assign unused_pattern_en = pattern_en;
  assign pat_eligible      = 1'b0;
  assign pat_frame         = '0;
  assign src               = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_buf_d = pend_buf_q;
    pend_vld_d = pend_vld_q;
    led_data_d = led_data_q;
    drop_d     = drop_q;
    launch_spi = 1'b0;
    launch_pat = 1'b0;

    case (state_q)
      IDLE: begin
        // A pulse arriving this very cycle becomes pending next cycle, so it
        // blocks a pattern launch now to let SPI win.
        if (!led_busy) begin
          if (pend_vld_q) begin
            launch_spi = 1'b1;
          end else if (pat_eligible && !spi_rdy) begin
            launch_pat = 1'b1;
          end
        end
        if (launch_spi || launch_pat) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = ACK;
        cnt_d   = '0;
      end
      ACK: begin
        if (led_busy) begin
          state_d = BUSY;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY: begin
        if (!led_busy) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // The chosen frame is registered on the edge into LOAD so led_data is
    // already valid while led_rdy is high; the pending slot is consumed there.
    if (launch_spi) begin
      led_data_d = pend_buf_q;
      pend_vld_d = 1'b0;
    end else if (launch_pat) begin
      led_data_d = pat_frame;
    end

    if (spi_rdy) begin
      pend_buf_d = spi_data;
      pend_vld_d = 1'b1;
      if (pend_vld_q && !launch_spi) begin
        drop_d = sat_inc8(drop_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_buf_q <= '0;
      pend_vld_q <= 1'b0;
      led_data_q <= '0;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_buf_q <= pend_buf_d;
      pend_vld_q <= pend_vld_d;
      led_data_q <= led_data_d;
      drop_q     <= drop_d;
    end
  end

  assign led_rdy  = (state_q == LOAD);
  assign led_data = led_data_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_rgbled_scheduler.sv
// Scoreboard bench for rgbled_scheduler: expected launches are queued as
// stimulus is driven and popped by a monitor whenever led_rdy pulses.
module tb_rgbled_scheduler;

  localparam int LEDS = 3;
  localparam int BPL  = 24;
  localparam int GAP  = 500;
  localparam int ACKT = 4;
  localparam int FW   = LEDS * BPL;

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] spi_data;
  logic          spi_rdy;
  logic          pattern_en;
  logic          led_busy;
  logic [FW-1:0] led_data;
  logic          led_rdy;
  logic          src;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  rgbled_scheduler #(
    .LEDS         (LEDS),
    .BITS_PER_LED (BPL),
    .GAP_CYCLES   (GAP),
    .ACK_TIMEOUT  (ACKT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_data   (spi_data),
    .spi_rdy    (spi_rdy),
    .pattern_en (pattern_en),
    .led_busy   (led_busy),
    .led_data   (led_data),
    .led_rdy    (led_rdy),
    .src        (src),
    .drop_cnt   (drop_cnt)
  );

  typedef struct packed {
    logic [FW-1:0] data;
    logic          src;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   launch_cnt   = 0;
  int   last_launch  = 0;
  int   busy_len     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (led_rdy === 1'b1) begin
      launch_cnt  = launch_cnt + 1;
      last_launch = cyc;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL launch_unexpected: got data=%h src=%b, required no launch", led_data, src);
      end else begin
        mon_e = exp_q.pop_front();
        if (led_data !== mon_e.data || src !== mon_e.src) begin
          tests_failed++;
          $display("FAIL launch_frame: got data=%h src=%b, required data=%h src=%b",
                   led_data, src, mon_e.data, mon_e.src);
        end
      end
    end
  end

  // Mock LED driver: raises led_busy for busy_len cycles after each launch.
  initial begin
    led_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (led_rdy === 1'b1 && busy_len > 0) begin
        led_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        led_busy = 1'b0;
      end
    end
  end

`ifdef RGBLED_SCHED_PATTERN_EN
  int exp_step = 0;

  function automatic logic [FW-1:0] pat_model(input int s);
    logic [FW-1:0] f;
    logic [23:0]   c;
    f = '0;
    for (int i = 0; i < LEDS; i++) begin
      case ((s + i) % 3)
        0:       c = 24'hFF0000;
        1:       c = 24'h00FF00;
        default: c = 24'h0000FF;
      endcase
      f[i*BPL +: BPL] = c;
    end
    return f;
  endfunction
`endif

  task automatic wait_launch(input int budget, output bit ok);
    int start;
    start = launch_cnt;
    ok    = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (launch_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_spi(input logic [FW-1:0] f, input bit expect_it, output int c0);
    @(negedge clk);
    spi_data = f;
    spi_rdy  = 1'b1;
    c0       = cyc;
    if (expect_it) exp_q.push_back('{data: f, src: 1'b0});
    @(negedge clk);
    spi_rdy = 1'b0;
  endtask

  task automatic settle();
    repeat (GAP + 80) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (led_data !== '0) begin
      tests_failed++; $display("FAIL reset_led_data: got %h required 0", led_data);
    end
    tests_run++;
    if (led_rdy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_led_rdy: got %b required 0", led_rdy);
    end
    tests_run++;
    if (src !== 1'b0) begin
      tests_failed++; $display("FAIL reset_src: got %b required 0", src);
    end
    tests_run++;
    if (drop_cnt !== 8'd0) begin
      tests_failed++; $display("FAIL reset_drop_cnt: got %0d required 0", drop_cnt);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_spi_idle();
    logic [FW-1:0] f;
    int c0;
    bit ok;
    f = 72'h0000FF_00FF00_FF0000;
    busy_len = 10;
    send_spi(f, 1'b1, c0);
    wait_launch(20, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL idle_launch_timeout: got no led_rdy required one");
    end else begin
      tests_run++;
      if (last_launch - c0 != 2) begin
        tests_failed++; $display("FAIL idle_latency: got %0d required 2", last_launch - c0);
      end
      tests_run++;
      if (src !== 1'b0) begin
        tests_failed++; $display("FAIL idle_src: got %b required 0", src);
      end
      @(negedge clk);
      #1;
      tests_run++;
      if (led_rdy !== 1'b0) begin
        tests_failed++; $display("FAIL idle_rdy_pulse: got %b required 0", led_rdy);
      end
      tests_run++;
      if (led_data !== f) begin
        tests_failed++; $display("FAIL idle_data_hold: got %h required %h", led_data, f);
      end
    end
    settle();
  endtask

  task automatic test_back_to_back();
    int c0, la;
    bit ok;
    busy_len = 30;
    send_spi(72'h111111_222222_333333, 1'b1, c0);
    wait_launch(20, ok);
    la = last_launch;
    repeat (5) @(negedge clk);
    send_spi(72'hAAAAAA_000001_000002, 1'b0, c0);
    send_spi(72'hBBBBBB_000003_000004, 1'b0, c0);
    send_spi(72'hCCCCCC_000005_000006, 1'b1, c0);
    wait_launch(busy_len + GAP + 60, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL b2b_launch_timeout: got no second launch required one");
    end else begin
      tests_run++;
      if (last_launch - la != busy_len + GAP + 2) begin
        tests_failed++;
        $display("FAIL b2b_spacing: got %0d required %0d", last_launch - la, busy_len + GAP + 2);
      end
    end
    tests_run++;
    if (drop_cnt !== 8'd2) begin
      tests_failed++; $display("FAIL b2b_drop_cnt: got %0d required 2", drop_cnt);
    end
    settle();
  endtask

  task automatic test_ack_timeout();
    int c0, la;
    bit ok;
    busy_len = 0;
    send_spi(72'h123456_789ABC_DEF012, 1'b1, c0);
    wait_launch(20, ok);
    la = last_launch;
    tests_run++;
    if (!ok || la - c0 != 2) begin
      tests_failed++; $display("FAIL ack_first_latency: got ok=%0d lat=%0d required ok=1 lat=2", ok, la - c0);
    end
    send_spi(72'h0F0F0F_F0F0F0_55AA55, 1'b1, c0);
    wait_launch(GAP + 60, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL ack_next_timeout: got no launch required one");
    end else begin
      tests_run++;
      if (last_launch - la != ACKT + GAP + 2) begin
        tests_failed++;
        $display("FAIL ack_spacing: got %0d required %0d", last_launch - la, ACKT + GAP + 2);
      end
    end
    tests_run++;
    if (drop_cnt !== 8'd2) begin
      tests_failed++; $display("FAIL ack_drop_cnt: got %0d required 2", drop_cnt);
    end
    settle();
  endtask

  task automatic test_pattern();
`ifdef RGBLED_SCHED_PATTERN_EN
    logic [23:0] led0_exp [4];
    int prev;
    bit ok;
    led0_exp = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF0000};
    busy_len = 10;
    prev     = 0;
    for (int k = 0; k < 4; k++) exp_q.push_back('{data: pat_model(k % 3), src: 1'b1});
    @(negedge clk);
    pattern_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_launch(GAP + 100, ok);
      tests_run++;
      if (!ok) begin
        tests_failed++; $display("FAIL pattern_launch_timeout: got no frame %0d required one", k);
        break;
      end
      if (k == 3) pattern_en = 1'b0;
      tests_run++;
      if (led_data[BPL-1:0] !== led0_exp[k]) begin
        tests_failed++;
        $display("FAIL pattern_led0_%0d: got %h required %h", k, led_data[BPL-1:0], led0_exp[k]);
      end
      if (k > 0) begin
        tests_run++;
        if (last_launch - prev < GAP) begin
          tests_failed++;
          $display("FAIL pattern_spacing_%0d: got %0d required >= %0d", k, last_launch - prev, GAP);
        end
      end
      prev = last_launch;
    end
    pattern_en = 1'b0;
    exp_step   = 1;
`else
    int start;
    @(negedge clk);
    pattern_en = 1'b1;
    start      = launch_cnt;
    repeat (GAP + 100) @(negedge clk);
    tests_run++;
    if (launch_cnt != start) begin
      tests_failed++; $display("FAIL pattern_ignored: got %0d launches required 0", launch_cnt - start);
    end
    tests_run++;
    if (src !== 1'b0) begin
      tests_failed++; $display("FAIL pattern_src: got %b required 0", src);
    end
    pattern_en = 1'b0;
`endif
    settle();
  endtask

  task automatic test_spi_vs_pattern();
    logic [FW-1:0] f;
    int c0;
    bit ok;
    f        = 72'hC0FFEE_BADA55_0DDBA1;
    busy_len = 10;
    @(negedge clk);
    spi_data   = f;
    spi_rdy    = 1'b1;
    pattern_en = 1'b1;
    c0         = cyc;
    exp_q.push_back('{data: f, src: 1'b0});
`ifdef RGBLED_SCHED_PATTERN_EN
    exp_q.push_back('{data: pat_model(exp_step), src: 1'b1});
`endif
    @(negedge clk);
    spi_rdy = 1'b0;
    wait_launch(20, ok);
    tests_run++;
    if (!ok || last_launch - c0 != 2) begin
      tests_failed++;
      $display("FAIL prio_latency: got ok=%0d lat=%0d required ok=1 lat=2", ok, last_launch - c0);
    end
    tests_run++;
    if (src !== 1'b0 || led_data !== f) begin
      tests_failed++; $display("FAIL prio_spi_wins: got src=%b data=%h required src=0 data=%h", src, led_data, f);
    end
`ifdef RGBLED_SCHED_PATTERN_EN
    wait_launch(GAP + 100, ok);
    pattern_en = 1'b0;
    tests_run++;
    if (!ok || src !== 1'b1) begin
      tests_failed++; $display("FAIL prio_followup_pattern: got ok=%0d src=%b required ok=1 src=1", ok, src);
    end
    exp_step = (exp_step + 1) % 3;
`endif
    settle();
    pattern_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int c0, start;
    bit ok;
    busy_len = 40;
    send_spi(72'h0A0B0C_0D0E0F_101112, 1'b1, c0);
    wait_launch(20, ok);
    repeat (5) @(negedge clk);
    send_spi(72'hDEAD00_BEEF00_FACE00, 1'b0, c0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (led_data !== '0 || led_rdy !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_data_rdy: got data=%h rdy=%b required 0/0", led_data, led_rdy);
    end
    tests_run++;
    if (src !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_src: got %b required 0", src);
    end
    tests_run++;
    if (drop_cnt !== 8'd0) begin
      tests_failed++; $display("FAIL midreset_drop_cnt: got %0d required 0", drop_cnt);
    end
    reset = 1'b0;
    start = launch_cnt;
    repeat (GAP + 100) @(negedge clk);
    tests_run++;
    if (launch_cnt != start) begin
      tests_failed++; $display("FAIL midreset_no_launch: got %0d launches required 0", launch_cnt - start);
    end
    send_spi(72'h314159_265358_979323, 1'b1, c0);
    wait_launch(20, ok);
    tests_run++;
    if (!ok || last_launch - c0 != 2) begin
      tests_failed++;
      $display("FAIL midreset_relaunch: got ok=%0d lat=%0d required ok=1 lat=2", ok, last_launch - c0);
    end
    settle();
  endtask

  initial begin
    reset      = 1'b1;
    spi_data   = '0;
    spi_rdy    = 1'b0;
    pattern_en = 1'b0;
    test_reset();
    test_spi_idle();
    test_back_to_back();
    test_ack_timeout();
    test_pattern();
    test_spi_vs_pattern();
    test_reset_mid();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL scoreboard_drain: got %0d outstanding required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rgbled_scheduler.md
RGBLED_SCHEDULER -- requirements
Module: rgbled_scheduler

Interface
REQ-001 The block SHALL have parameter LEDS, default 3, giving the number of LEDs in the chain.
REQ-002 The block SHALL have parameter BITS_PER_LED, default 24, giving the bits per LED (GRB, MSB first).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 500, giving the minimum idle cycles between frames (latch gap).
REQ-004 The block SHALL have parameter ACK_TIMEOUT, default 4, giving the cycles to wait for led_busy after launch.
REQ-005 The block SHALL have port clk, input, width 1: the single clock, all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, width 1: reset, synchronous and active-high.
REQ-007 The block SHALL have port spi_data, input, width LEDS*BITS_PER_LED: the frame from the SPI receiver; LED i occupies [i*BITS_PER_LED +: BITS_PER_LED].
REQ-008 The block SHALL have port spi_rdy, input, width 1: a one-cycle pulse, spi_data valid.
REQ-009 The block SHALL have port pattern_en, input, width 1: it enables autonomous test-pattern frames.
REQ-010 The block SHALL have port led_busy, input, width 1: high while the LED driver is shifting a frame.
REQ-011 The block SHALL have port led_data, output, width LEDS*BITS_PER_LED: the frame to the LED driver, held stable between launches.
REQ-012 The block SHALL have port led_rdy, output, width 1: a one-cycle launch pulse to the driver.
REQ-013 The block SHALL have port src, output, width 1: the source of the last launched frame (0 = SPI, 1 = pattern).
REQ-014 The block SHALL have port drop_cnt, output, width 8: a saturating count of overwritten, never-sent SPI frames.

Function
REQ-015 The block SHALL use the FSM states IDLE, LOAD, ACK, BUSY and GAP.
REQ-016 Any spi_rdy SHALL capture spi_data into the pending buffer and set pending_valid.
REQ-017 When spi_rdy arrives while pending_valid=1, the new frame SHALL overwrite the pending buffer and drop_cnt SHALL increment, saturating at 255, except as in REQ-020.
REQ-018 In IDLE with led_busy=0, the FSM SHALL go to LOAD if pending_valid=1; otherwise, if pattern_en=1, it SHALL go to LOAD with the pattern source; otherwise it SHALL stay in IDLE.
REQ-019 SPI SHALL always win over pattern when both are eligible in the same cycle.
REQ-020 In LOAD, led_data SHALL take the selected frame, led_rdy SHALL be 1 for exactly that cycle, src SHALL update, and pending_valid SHALL clear unless spi_rdy is high in that same cycle, in which case the new frame becomes pending and is not counted as a drop.
REQ-021 In ACK, the FSM SHALL go to BUSY when led_busy=1, or to GAP after ACK_TIMEOUT cycles with led_busy=0.
REQ-022 In BUSY, the FSM SHALL wait for led_busy=0 and then go to GAP.
REQ-023 In GAP, the FSM SHALL count GAP_CYCLES cycles and then go to IDLE; led_rdy SHALL never assert during ACK, BUSY or GAP.
REQ-024 The latency from spi_rdy with the FSM in IDLE and led_busy=0 SHALL be exactly 2 cycles to led_rdy (capture cycle, then LOAD).
REQ-025 Pattern frame contents SHALL be: LED i = colour[(step+i) mod 3], with colour0 = 24'hFF0000, colour1 = 24'h00FF00, colour2 = 24'h0000FF, zero-extended or truncated to BITS_PER_LED.
REQ-026 step SHALL increment 0->1->2->0 after each launched pattern frame.

Reset
REQ-027 While reset=1, the state SHALL be IDLE, and led_data, led_rdy, src, drop_cnt, pending_valid, step and all counters SHALL be 0.
REQ-028 A reset asserted mid-operation (any state) SHALL abandon the frame, with led_rdy low from the next edge and no partial state retained.

Configuration
REQ-029 When macro RGBLED_SCHED_PATTERN_EN is defined, the pattern source and step counter SHALL be compiled in per REQ-018 and REQ-025/026.
REQ-030 Without RGBLED_SCHED_PATTERN_EN, pattern_en SHALL be ignored, src SHALL be constant 0, and no pattern logic SHALL be synthesized; the port list SHALL be unchanged.

Structure
REQ-031 Package rgbled_sched_pkg SHALL hold the FSM state enum and the three colour constants.
REQ-032 The pattern generation SHALL be a sub-module rgbled_pattern_gen (step in, frame out, advance strobe), instantiated only under RGBLED_SCHED_PATTERN_EN.

Verification
REQ-033 The bench SHALL cover: spi_rdy with frame 72'h0000FF_00FF00_FF0000 while idle -> led_rdy at +2 cycles, led_data equal to the frame, src=0.
REQ-034 The bench SHALL cover: three spi_rdy pulses during BUSY -> one launch of the third frame after GAP, drop_cnt=2.
REQ-035 The bench SHALL cover: pattern_en=1 with no SPI traffic and the driver mocked at 10 busy cycles -> frames steps 0,1,2,0, with LED0 = FF0000, 00FF00, 0000FF, FF0000, and launches at least GAP_CYCLES apart.
REQ-036 The bench SHALL cover: spi_rdy coinciding with a pattern eligibility in IDLE -> the SPI frame is launched, src=0, and step is unchanged.
REQ-037 The bench SHALL cover: a driver that never raises led_busy -> ACK times out after 4 cycles, GAP is entered, and the next launch follows normally.
REQ-038 The bench SHALL cover: reset asserted in BUSY with pending_valid=1 -> all outputs 0 next cycle and no launch until new spi_rdy.
